fsk_symbol_framer: RTL and testbench

Upstream feeder for the FSK modulator. It accepts a byte stream on a valid/ready interface and buffers it in a small FIFO. It slices the bytes into M-FSK symbols (16/8/4/2-FSK) and drives the modulator's 4-bit frequency index and start pulse. Each symbol is held for a fixed number of sample clocks, and the framer waits out the modulator's sync preamble before the first data symbol period.

---
 rtl/fsk_pkg.sv | 42 ++++
 rtl/fsk_symbol_framer_if.sv | 21 ++
 rtl/fsk_byte_fifo.sv | 62 ++++++
 rtl/fsk_symbol_framer.sv | 217 +++++++++++++++++++++
 tb/tb_fsk_symbol_framer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK symbol framer and its modulator: mode
// encodings, bits-per-symbol decode, framer state enum and the minimum
// preamble wait the modulator needs before the first data symbol.
package fsk_pkg;

  localparam logic [1:0] MODE_16FSK = 2'b00;
  localparam logic [1:0] MODE_8FSK  = 2'b01;
  localparam logic [1:0] MODE_4FSK  = 2'b10;
  localparam logic [1:0] MODE_2FSK  = 2'b11;

  // Modulator sync preamble length; the framer must wait at least this plus 2.
  localparam int unsigned MOD_SYNC_LEN  = 8;
  localparam int unsigned SYNC_WAIT_MIN = MOD_SYNC_LEN + 2;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StSym,
    StPar,
    StGap
  } state_e;

  function automatic logic [2:0] bits_per_sym(input logic [1:0] mode);
    logic [2:0] k;
    case (mode)
      MODE_16FSK: k = 3'd4;
      MODE_8FSK:  k = 3'd3;
      MODE_4FSK:  k = 3'd2;
      default:    k = 3'd1;
    endcase
    return k;
  endfunction

  // Mask selecting the top k bits of a nibble, i.e. a k-bit value already
  // shifted into the 16-tone index space.
  function automatic logic [3:0] sym_mask(input logic [2:0] k);
    logic [3:0] m;
    m = 4'hF << (3'd4 - k);
    return m;
  endfunction

endpackage

// File: rtl/fsk_symbol_framer_if.sv
// Byte stream valid/ready channel feeding the FSK symbol framer.
interface fsk_symbol_framer_if;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;

  modport master (
    output s_data,
    output s_last,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_last,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/fsk_byte_fifo.sv
// Synchronous FIFO of {last, data[7:0]} entries with full/empty/level.
// Read data is the current head (combinational from the storage array).
module fsk_byte_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [8:0]                 wdata_i,
  input  logic                       pop_i,
  output logic [8:0]                 rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     level_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;

  logic [8:0]    mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == LW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fsk_symbol_framer.sv
// FSK symbol framer: buffers bytes, slices them MSB-first into k-bit M-FSK
// symbols, holds each symbol for SPS clocks after a SYNC_WAIT preamble, then
// idles for GAP_LEN clocks. Optional macro FSK_FRAMER_PARITY_EN appends one
// XOR parity symbol after the last data symbol.
module fsk_symbol_framer
  import fsk_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SPS        = 64,
  parameter int unsigned SYNC_WAIT  = 12,
  parameter int unsigned GAP_LEN    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  fsk_symbol_framer_if.slave            s,
  output logic [3:0]                    sym_out,
  output logic                          start_out,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CntMax = (SPS > SYNC_WAIT) ?
                                   ((SPS > GAP_LEN) ? SPS : GAP_LEN) :
                                   ((SYNC_WAIT > GAP_LEN) ? SYNC_WAIT : GAP_LEN);
  localparam int unsigned CW = $clog2(CntMax + 1);

  if (SYNC_WAIT < SYNC_WAIT_MIN) begin : g_sync_wait_check
    $error("SYNC_WAIT shorter than modulator preamble");
  end

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  sym_q, sym_d;
  logic [2:0]  k_q, k_d;
  logic [10:0] buf_q, buf_d;      // left-aligned, unused low bits kept zero
  logic [3:0]  nbits_q, nbits_d;
  logic        last_seen_q, last_seen_d;
  logic        underrun_q, underrun_d;
`ifdef FSK_FRAMER_PARITY_EN
  logic [3:0]  par_q, par_d;
`endif

  logic [8:0]  fifo_rdata;
  logic        fifo_full, fifo_empty, fifo_pop;

  logic        is_idle;
  logic [2:0]  k_use;
  logic [10:0] buf_base, buf_fill, buf_after;
  logic [3:0]  n_base, n_fill, n_after;
  logic        last_base, last_fill, can_fill;
  logic        have_sym, pad_sym, starve;
  logic [3:0]  next_sym;

  fsk_byte_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (s.s_valid),
    .wdata_i ({s.s_last, s.s_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Candidate next symbol: optional refill from the FIFO head, then slice k bits.
  // In IDLE the bit buffer is treated as empty and k comes from the live mode.
  always_comb begin
    is_idle   = (state_q == StIdle);
    k_use     = is_idle ? bits_per_sym(mode) : k_q;
    buf_base  = is_idle ? 11'd0 : buf_q;
    n_base    = is_idle ? 4'd0 : nbits_q;
    last_base = is_idle ? 1'b0 : last_seen_q;
    // Never pull bytes past s_last: they belong to the next frame.
    can_fill  = !fifo_empty && !last_base && (n_base < {1'b0, k_use});
    buf_fill  = can_fill ? (buf_base | ({fifo_rdata[7:0], 3'b000} >> n_base)) : buf_base;
    n_fill    = can_fill ? (n_base + 4'd8) : n_base;
    last_fill = last_base | (can_fill & fifo_rdata[8]);
    have_sym  = (n_fill >= {1'b0, k_use});
    pad_sym   = !have_sym && last_fill && (n_fill != 4'd0);
    starve    = !have_sym && !last_fill;
    next_sym  = buf_fill[10:7] & sym_mask(k_use);
    buf_after = buf_fill << k_use;
    n_after   = have_sym ? (n_fill - {1'b0, k_use}) : 4'd0;
  end

  // Framer FSM next state and datapath updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    sym_d       = sym_q;
    k_d         = k_q;
    buf_d       = buf_q;
    nbits_d     = nbits_q;
    last_seen_d = last_seen_q;
    underrun_d  = underrun_q;
    fifo_pop    = 1'b0;
`ifdef FSK_FRAMER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        sym_d = 4'd0;
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          k_d         = k_use;
          buf_d       = buf_after;
          nbits_d     = n_after;
          last_seen_d = last_fill;
          sym_d       = next_sym;
          state_d     = StSync;
`ifdef FSK_FRAMER_PARITY_EN
          par_d       = next_sym;
`endif
        end
      end
      StSync: begin
        if (cnt_q == CW'(SYNC_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = StSym;
        end
      end
      StSym: begin
        if (cnt_q == CW'(SPS - 1)) begin
          cnt_d = '0;
          if (have_sym || pad_sym) begin
            fifo_pop    = can_fill;
            sym_d       = next_sym;
            buf_d       = buf_after;
            nbits_d     = n_after;
            last_seen_d = last_fill;
`ifdef FSK_FRAMER_PARITY_EN
            par_d       = par_q ^ next_sym;
`endif
          end else if (starve) begin
            // Emit a silent period and retry at the next boundary.
            sym_d      = 4'd0;
            underrun_d = 1'b1;
          end else begin
`ifdef FSK_FRAMER_PARITY_EN
            sym_d   = par_q;
            state_d = StPar;
`else
            sym_d   = 4'd0;
            state_d = StGap;
`endif
          end
        end
      end
`ifdef FSK_FRAMER_PARITY_EN
      StPar: begin
        if (cnt_q == CW'(SPS - 1)) begin
          cnt_d   = '0;
          sym_d   = 4'd0;
          state_d = StGap;
        end
      end
`endif
      StGap: begin
        if (cnt_q == CW'(GAP_LEN - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        sym_d   = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  // Framer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sym_q       <= 4'd0;
      k_q         <= 3'd4;
      buf_q       <= '0;
      nbits_q     <= '0;
      last_seen_q <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef FSK_FRAMER_PARITY_EN
      par_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      k_q         <= k_d;
      buf_q       <= buf_d;
      nbits_q     <= nbits_d;
      last_seen_q <= last_seen_d;
      underrun_q  <= underrun_d;
`ifdef FSK_FRAMER_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // SYNC is only entered from IDLE, so its first cycle is the start cycle.
  assign start_out  = (state_q == StSync) && (cnt_q == '0);
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StGap) && (cnt_q == CW'(GAP_LEN - 1));
  assign underrun   = underrun_q;
  assign sym_out    = sym_q;
  // Held low during reset so every output reads 0 while reset is asserted.
  assign s.s_ready  = !fifo_full && !reset;

endmodule

// File: tb/tb_fsk_symbol_framer.sv
// Self-checking bench for fsk_symbol_framer: expected symbols are queued as
// bytes are driven and compared as the framer emits them.
module tb_fsk_symbol_framer;

  localparam int unsigned FifoDepth = 16;
  localparam int unsigned Sps       = 64;
  localparam int unsigned SyncWait  = 12;
  localparam int unsigned GapLen    = 32;
  localparam int unsigned LW        = $clog2(FifoDepth) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [3:0]    sym_out;
  logic          start_out, busy, frame_done, underrun;
  logic [LW-1:0] fifo_level;

  fsk_symbol_framer_if bus ();

  fsk_symbol_framer #(
    .FIFO_DEPTH (FifoDepth),
    .SPS        (Sps),
    .SYNC_WAIT  (SyncWait),
    .GAP_LEN    (GapLen)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .s          (bus),
    .sym_out    (sym_out),
    .start_out  (start_out),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int par_acc = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; the byte is pushed on the following posedge.
  task automatic push_byte(input logic [7:0] d, input logic last);
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic exp_sym(input int v);
    exp_q.push_back(v);
    par_acc ^= v;
  endtask

  task automatic exp_silent();
    exp_q.push_back(0);
  endtask

  task automatic exp_end();
`ifdef FSK_FRAMER_PARITY_EN
    exp_q.push_back(par_acc);
`endif
    exp_q.push_back(-1);
    par_acc = 0;
  endtask

  task automatic wait_start(output bit seen);
    int to = 0;
    while (start_out !== 1'b1 && to < 200) begin
      @(negedge clk);
      to++;
    end
    seen = (start_out === 1'b1);
    check_eq("start_seen", int'(seen), 1);
  endtask

  // Consumes the scoreboard for one frame: symbols, then the GAP marker (-1).
  task automatic monitor_frame();
    bit seen;
    bit first = 1'b1;
    int e, dur, bad, first_val, starts, gbad, dbad;
    wait_start(seen);
    if (!seen) begin
      exp_q.delete();
      return;
    end
    starts = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e < 0) begin
        gbad = 0;
        dbad = 0;
        for (int d = 0; d < GapLen; d++) begin
          if (sym_out != 4'd0) gbad++;
          if (frame_done != (d == GapLen - 1)) dbad++;
          if (start_out) starts++;
          @(negedge clk);
        end
        check_eq("gap_sym_nonzero_cycles", gbad, 0);
        check_eq("frame_done_bad_cycles", dbad, 0);
        check_eq("busy_after_gap", int'(busy), 0);
        break;
      end
      dur = first ? SyncWait + Sps : Sps;
      first = 1'b0;
      first_val = int'(sym_out);
      bad = 0;
      for (int d = 0; d < dur; d++) begin
        if (int'(sym_out) != e) bad++;
        if (start_out) starts++;
        @(negedge clk);
      end
      check_eq("sym_value", first_val, e);
      check_eq("sym_hold_bad_cycles", bad, 0);
    end
    check_eq("start_pulses", starts, 1);
  endtask

  initial begin
    bit seen;
    reset       = 1'b1;
    mode        = 2'b00;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_sym_out", int'(sym_out), 0);
    check_eq("rst_start_out", int'(start_out), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_frame_done", int'(frame_done), 0);
    check_eq("rst_underrun", int'(underrun), 0);
    check_eq("rst_fifo_level", int'(fifo_level), 0);
    check_eq("rst_s_ready", int'(bus.s_ready), 1);

    // 16-FSK single byte
    mode = 2'b00;
    exp_sym(4'hA); exp_sym(4'h5); exp_end();
    push_byte(8'hA5, 1'b1);
    check_eq("level_after_push", int'(fifo_level), 1);
    monitor_frame();

    // 4-FSK; a mode change after start must not affect this frame
    mode = 2'b10;
    exp_sym(8); exp_sym(8); exp_sym(4); exp_sym(4); exp_end();
    push_byte(8'hA5, 1'b1);
    fork
      monitor_frame();
      begin
        wait_start(seen);
        mode = 2'b00;
      end
    join

    // 8-FSK across a byte boundary with a padded final symbol
    mode = 2'b01;
    exp_sym(10); exp_sym(2); exp_sym(6); exp_sym(14); exp_sym(14); exp_sym(8); exp_end();
    push_byte(8'hA5, 1'b0);
    push_byte(8'hFF, 1'b1);
    monitor_frame();

    // 2-FSK
    mode = 2'b11;
    exp_sym(8);
    for (int i = 0; i < 6; i++) exp_sym(0);
    exp_sym(8);
    exp_end();
    push_byte(8'h81, 1'b1);
    monitor_frame();
    check_eq("underrun_before_stall", int'(underrun), 0);

    // Underrun then resume
    mode = 2'b00;
    exp_sym(1); exp_sym(2); exp_silent(); exp_sym(3); exp_sym(4'hC); exp_end();
    push_byte(8'h12, 1'b0);
    fork
      monitor_frame();
      begin
        wait_start(seen);
        repeat (SyncWait + 2 * Sps + 10) @(negedge clk);
        check_eq("underrun_set", int'(underrun), 1);
        push_byte(8'h3C, 1'b1);
      end
    join
    check_eq("underrun_sticky", int'(underrun), 1);
    check_eq("sb_drained", exp_q.size(), 0);

    // Fill the FIFO behind a running frame, then reset mid-symbol
    mode = 2'b00;
    push_byte(8'h77, 1'b1);
    wait_start(seen);
    for (int i = 0; i < int'(FifoDepth); i++) begin
      if (i == 0 || i == int'(FifoDepth) - 1)
        check_eq("s_ready_while_filling", int'(bus.s_ready), 1);
      push_byte(8'(i), 1'b0);
    end
    check_eq("full_level", int'(fifo_level), FifoDepth);
    check_eq("full_s_ready", int'(bus.s_ready), 0);
    bus.s_data  = 8'hEE;
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    check_eq("full_level_after_blocked_push", int'(fifo_level), FifoDepth);
    repeat (SyncWait) @(negedge clk);
    check_eq("busy_mid_sym", int'(busy), 1);
    check_eq("sym_mid_sym", int'(sym_out), 7);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_sym_out", int'(sym_out), 0);
    check_eq("mid_rst_start_out", int'(start_out), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_frame_done", int'(frame_done), 0);
    check_eq("mid_rst_underrun", int'(underrun), 0);
    check_eq("mid_rst_fifo_level", int'(fifo_level), 0);
    check_eq("mid_rst_s_ready", int'(bus.s_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_s_ready", int'(bus.s_ready), 1);
    repeat (5) @(negedge clk);
    check_eq("post_rst_busy", int'(busy), 0);
    check_eq("post_rst_level", int'(fifo_level), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
